// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the riscv_fetch stage and its instruction buffer.
package riscv_fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   localparam logic [PC_W-1:0]    BOOT_VECTOR_DEF = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP             = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               fault_fetch;
      logic               fault_page;
   } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t; flush wins over push and pop.
module riscv_fetch_fifo
   import riscv_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 din,
   input  logic                         pop,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap without explicit compare.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_fetch.sv
// PC generation and instruction fetch: one outstanding icache request, buffered
// responses, redirect handling and a registered squash pulse toward decode.
module riscv_fetch
   import riscv_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] BOOT_VECTOR = BOOT_VECTOR_DEF,
   parameter int              FIFO_DEPTH  = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                branch_request_i,
   input  logic [PC_W-1:0]     branch_pc_i,
   output logic                icache_rd_o,
   output logic [PC_W-1:0]     icache_pc_o,
   input  logic                icache_accept_i,
   input  logic                icache_valid_i,
   input  logic [INSTR_W-1:0]  icache_inst_i,
   input  logic                icache_error_i,
   input  logic                icache_page_fault_i,
   output logic                fetch_out_valid_o,
   output logic [INSTR_W-1:0]  fetch_out_instr_o,
   output logic [PC_W-1:0]     fetch_out_pc_o,
   output logic                fetch_out_fault_fetch_o,
   output logic                fetch_out_fault_page_o,
   input  logic                fetch_in_accept_i,
   output logic                squash_decode_o,
   output fetch_state_e        debug_state_o
);

   // Handshakes: icache request transfers on icache_rd_o & icache_accept_i with
   // rd/pc held stable until then; decode transfers on fetch_out_valid_o &
   // fetch_in_accept_i with fetch_out_* held stable until then.

   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

   fetch_state_e  state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] req_pc_q, req_pc_d;
   logic          outstanding_q, outstanding_d;
   logic          discard_q, discard_d;
   logic          squash_q;

   logic          push;
   logic          pop;
   logic          resp_fault;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic [CW:0]   occ;
   logic [CW:0]   count_after;

   assign resp_fault = icache_error_i | icache_page_fault_i;
   assign push_entry = '{pc:          req_pc_q,
                         instr:       resp_fault ? '0 : icache_inst_i,
                         fault_fetch: icache_error_i,
                         fault_page:  icache_page_fault_i};
   assign pop = !empty && fetch_in_accept_i;
   assign occ = {1'b0, count} + {{CW{1'b0}}, outstanding_q};

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      req_pc_d      = req_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      push          = 1'b0;
      count_after   = {1'b0, count} - {{CW{1'b0}}, pop};

      case (state_q)
         IDLE: begin
            if (occ < DEPTH_L) state_d = REQ;
         end
         REQ: begin
            if (icache_accept_i) begin
               pc_d          = pc_q + 32'd4;
               req_pc_d      = pc_q;
               outstanding_d = 1'b1;
               state_d       = WAIT;
            end
         end
         WAIT: begin
            if (icache_valid_i) begin
               outstanding_d = 1'b0;
               discard_d     = 1'b0;
               if (!discard_q && !branch_request_i) begin
                  push        = 1'b1;
                  count_after = count_after + (CW+1)'(1);
               end
               if (push && resp_fault)        state_d = HALT;
               else if (count_after < DEPTH_L) state_d = REQ;
               else                            state_d = IDLE;
            end
         end
         default: ;
      endcase

      // Redirect overrides whatever the state decode above chose.
      if (branch_request_i) begin
         pc_d = {branch_pc_i[PC_W-1:2], 2'b00};
         case (state_q)
            REQ: begin
               if (icache_accept_i) discard_d = 1'b1;
            end
            WAIT: begin
               if (icache_valid_i) state_d = REQ;
               else                discard_d = 1'b1;
            end
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         pc_q          <= BOOT_VECTOR;
         req_pc_q      <= BOOT_VECTOR;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
         squash_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         squash_q      <= branch_request_i;
      end
   end

   riscv_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .flush (branch_request_i),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign icache_rd_o             = (state_q == REQ);
   assign icache_pc_o             = pc_q;
   assign fetch_out_valid_o       = !empty;
   assign fetch_out_instr_o       = empty ? '0 : head.instr;
   assign fetch_out_pc_o          = empty ? '0 : head.pc;
   assign fetch_out_fault_fetch_o = !empty && head.fault_fetch;
   assign fetch_out_fault_page_o  = !empty && head.fault_page;
   assign squash_decode_o         = squash_q;
   assign debug_state_o           = state_q;

   logic unused_full;
   assign unused_full = full;

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: sequential fetch, back-pressure, redirects,
// faults, PC wrap and reset while a request is outstanding.
module tb_riscv_fetch;
   import riscv_fetch_pkg::*;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               branch_request_i;
   logic [31:0]        branch_pc_i;
   logic               icache_rd_o;
   logic [31:0]        icache_pc_o;
   logic               icache_accept_i;
   logic               icache_valid_i;
   logic [31:0]        icache_inst_i;
   logic               icache_error_i;
   logic               icache_page_fault_i;
   logic               fetch_out_valid_o;
   logic [31:0]        fetch_out_instr_o;
   logic [31:0]        fetch_out_pc_o;
   logic               fetch_out_fault_fetch_o;
   logic               fetch_out_fault_page_o;
   logic               fetch_in_accept_i;
   logic               squash_decode_o;
   fetch_state_e       debug_state_o;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   riscv_fetch #(
      .BOOT_VECTOR (32'h0000_0000),
      .FIFO_DEPTH  (2)
   ) dut (
      .clk_i                   (clk_i),
      .rst_i                   (rst_i),
      .branch_request_i        (branch_request_i),
      .branch_pc_i             (branch_pc_i),
      .icache_rd_o             (icache_rd_o),
      .icache_pc_o             (icache_pc_o),
      .icache_accept_i         (icache_accept_i),
      .icache_valid_i          (icache_valid_i),
      .icache_inst_i           (icache_inst_i),
      .icache_error_i          (icache_error_i),
      .icache_page_fault_i     (icache_page_fault_i),
      .fetch_out_valid_o       (fetch_out_valid_o),
      .fetch_out_instr_o       (fetch_out_instr_o),
      .fetch_out_pc_o          (fetch_out_pc_o),
      .fetch_out_fault_fetch_o (fetch_out_fault_fetch_o),
      .fetch_out_fault_page_o  (fetch_out_fault_page_o),
      .fetch_in_accept_i       (fetch_in_accept_i),
      .squash_decode_o         (squash_decode_o),
      .debug_state_o           (debug_state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      branch_request_i    = 1'b0;
      branch_pc_i         = '0;
      icache_accept_i     = 1'b0;
      icache_valid_i      = 1'b0;
      icache_inst_i       = '0;
      icache_error_i      = 1'b0;
      icache_page_fault_i = 1'b0;
      fetch_in_accept_i   = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      clear_inputs();
      step();
      step();
      rst_i = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_rd",    icache_rd_o, 0);
      check("rst_pc",    icache_pc_o, 32'h0);
      check("rst_valid", fetch_out_valid_o, 0);
      check("rst_squash", squash_decode_o, 0);
      check("rst_opc",   fetch_out_pc_o, 32'h0);
      check("rst_instr", fetch_out_instr_o, 32'h0);
      check("rst_state", 32'(debug_state_o), 32'(IDLE));

      // Sequential fetch, 1-cycle memory, decode always accepting
      fetch_in_accept_i = 1'b1;
      step();
      check("t1_first_valid", fetch_out_valid_o, 0);
      for (int k = 0; k < 4; k++) begin
         check("t1_rd", icache_rd_o, 1);
         check("t1_icpc", icache_pc_o, 32'(4*k));
         icache_accept_i = 1'b1;
         icache_valid_i  = 1'b0;
         step();
         check("t1_wait_rd", icache_rd_o, 0);
         check("t1_wait_valid", fetch_out_valid_o, 0);
         icache_accept_i = 1'b0;
         icache_valid_i  = 1'b1;
         icache_inst_i   = 32'hA5A5_0000 | 32'(4*k);
         step();
         icache_valid_i  = 1'b0;
         check("t1_valid", fetch_out_valid_o, 1);
         check("t1_opc",   fetch_out_pc_o, 32'(4*k));
         check("t1_instr", fetch_out_instr_o, 32'hA5A5_0000 | 32'(4*k));
      end

      // Back-pressure fills the buffer to FIFO_DEPTH and stops requests
      do_reset();
      step();
      icache_accept_i = 1'b1;
      step();
      icache_accept_i = 1'b0;
      icache_valid_i  = 1'b1;
      icache_inst_i   = 32'h1111_0000;
      step();
      check("t2_rd2", icache_rd_o, 1);
      check("t2_icpc2", icache_pc_o, 32'h4);
      icache_valid_i  = 1'b0;
      icache_accept_i = 1'b1;
      step();
      icache_accept_i = 1'b0;
      icache_valid_i  = 1'b1;
      icache_inst_i   = 32'h1111_0004;
      step();
      icache_valid_i  = 1'b0;
      check("t2_full_rd", icache_rd_o, 0);
      check("t2_full_state", 32'(debug_state_o), 32'(IDLE));
      for (int c = 0; c < 10; c++) begin
         step();
         check("t2_hold_rd",    icache_rd_o, 0);
         check("t2_hold_valid", fetch_out_valid_o, 1);
         check("t2_hold_opc",   fetch_out_pc_o, 32'h0);
      end
      check("t2_hold_instr", fetch_out_instr_o, 32'h1111_0000);
      fetch_in_accept_i = 1'b1;
      step();
      check("t2_pop_opc", fetch_out_pc_o, 32'h4);
      check("t2_pop_rd",  icache_rd_o, 0);
      step();
      check("t2_resume_rd",    icache_rd_o, 1);
      check("t2_resume_icpc",  icache_pc_o, 32'h8);
      check("t2_resume_valid", fetch_out_valid_o, 0);

      // Redirect while waiting for a response
      icache_accept_i = 1'b1;
      step();
      icache_accept_i  = 1'b0;
      branch_request_i = 1'b1;
      branch_pc_i      = 32'h0000_0103;
      step();
      branch_request_i = 1'b0;
      check("t3_squash", squash_decode_o, 1);
      check("t3_rd",     icache_rd_o, 0);
      check("t3_icpc",   icache_pc_o, 32'h100);
      icache_valid_i = 1'b1;
      icache_inst_i  = 32'hBAD0_0008;
      step();
      icache_valid_i = 1'b0;
      check("t3_squash_end", squash_decode_o, 0);
      check("t3_dropped",    fetch_out_valid_o, 0);
      check("t3_req_rd",     icache_rd_o, 1);
      check("t3_req_icpc",   icache_pc_o, 32'h100);
      icache_accept_i = 1'b1;
      step();
      icache_accept_i = 1'b0;
      icache_valid_i  = 1'b1;
      icache_inst_i   = 32'h2222_0100;
      step();
      icache_valid_i  = 1'b0;
      check("t3_opc0",   fetch_out_pc_o, 32'h100);
      check("t3_instr0", fetch_out_instr_o, 32'h2222_0100);
      icache_accept_i = 1'b1;
      step();
      icache_accept_i = 1'b0;
      icache_valid_i  = 1'b1;
      icache_inst_i   = 32'h2222_0104;
      step();
      icache_valid_i  = 1'b0;
      check("t3_opc1", fetch_out_pc_o, 32'h104);

      // Redirect of an unaccepted request, then a bus error halts fetching
      branch_request_i = 1'b1;
      branch_pc_i      = 32'h0000_0020;
      step();
      branch_request_i = 1'b0;
      check("t4_squash",  squash_decode_o, 1);
      check("t4_rd",      icache_rd_o, 1);
      check("t4_icpc",    icache_pc_o, 32'h20);
      check("t4_flushed", fetch_out_valid_o, 0);
      icache_accept_i = 1'b1;
      step();
      icache_accept_i   = 1'b0;
      fetch_in_accept_i = 1'b0;
      icache_valid_i    = 1'b1;
      icache_inst_i     = 32'hDEAD_BEEF;
      icache_error_i    = 1'b1;
      step();
      icache_valid_i = 1'b0;
      icache_error_i = 1'b0;
      check("t4_err_valid", fetch_out_valid_o, 1);
      check("t4_err_opc",   fetch_out_pc_o, 32'h20);
      check("t4_err_instr", fetch_out_instr_o, 32'h0);
      check("t4_err_ff",    fetch_out_fault_fetch_o, 1);
      check("t4_err_fp",    fetch_out_fault_page_o, 0);
      check("t4_err_state", 32'(debug_state_o), 32'(HALT));
      fetch_in_accept_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("t4_halt_rd", icache_rd_o, 0);
      end
      check("t4_halt_valid", fetch_out_valid_o, 0);
      branch_request_i = 1'b1;
      branch_pc_i      = 32'h0000_0040;
      step();
      branch_request_i = 1'b0;
      check("t4_resume_rd",   icache_rd_o, 1);
      check("t4_resume_icpc", icache_pc_o, 32'h40);
      icache_accept_i = 1'b1;
      step();
      icache_accept_i     = 1'b0;
      fetch_in_accept_i   = 1'b0;
      icache_valid_i      = 1'b1;
      icache_inst_i       = 32'h1234_5678;
      icache_error_i      = 1'b1;
      icache_page_fault_i = 1'b1;
      step();
      icache_valid_i      = 1'b0;
      icache_error_i      = 1'b0;
      icache_page_fault_i = 1'b0;
      check("t4_both_opc",   fetch_out_pc_o, 32'h40);
      check("t4_both_instr", fetch_out_instr_o, 32'h0);
      check("t4_both_ff",    fetch_out_fault_fetch_o, 1);
      check("t4_both_fp",    fetch_out_fault_page_o, 1);
      check("t4_both_rd",    icache_rd_o, 0);

      // PC wrap at the top of the address space (target also tests alignment)
      fetch_in_accept_i = 1'b1;
      branch_request_i  = 1'b1;
      branch_pc_i       = 32'hFFFF_FFFE;
      step();
      branch_request_i = 1'b0;
      check("t5_rd",   icache_rd_o, 1);
      check("t5_icpc", icache_pc_o, 32'hFFFF_FFFC);
      icache_accept_i = 1'b1;
      step();
      icache_accept_i = 1'b0;
      check("t5_wrap_icpc", icache_pc_o, 32'h0);
      icache_valid_i = 1'b1;
      icache_inst_i  = NOP;
      step();
      icache_valid_i = 1'b0;
      check("t5_opc",     fetch_out_pc_o, 32'hFFFF_FFFC);
      check("t5_instr",   fetch_out_instr_o, 32'h0000_0013);
      check("t5_next_rd", icache_rd_o, 1);
      check("t5_next_pc", icache_pc_o, 32'h0);

      // Reset while a request is outstanding; late response is ignored
      icache_accept_i = 1'b1;
      step();
      icache_accept_i = 1'b0;
      check("t6_wait_icpc", icache_pc_o, 32'h4);
      rst_i = 1'b1;
      step();
      check("t6_rst_rd",    icache_rd_o, 0);
      check("t6_rst_icpc",  icache_pc_o, 32'h0);
      check("t6_rst_valid", fetch_out_valid_o, 0);
      rst_i          = 1'b0;
      icache_valid_i = 1'b1;
      icache_inst_i  = 32'hBAD0_0000;
      step();
      icache_valid_i = 1'b0;
      check("t6_ignored", fetch_out_valid_o, 0);
      check("t6_rd",      icache_rd_o, 1);
      check("t6_icpc",    icache_pc_o, 32'h0);
      icache_accept_i = 1'b1;
      step();
      icache_accept_i = 1'b0;
      icache_valid_i  = 1'b1;
      icache_inst_i   = 32'h0000_1111;
      step();
      icache_valid_i  = 1'b0;
      check("t6_valid", fetch_out_valid_o, 1);
      check("t6_opc",   fetch_out_pc_o, 32'h0);
      check("t6_instr", fetch_out_instr_o, 32'h0000_1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_fetch.md
Name: riscv_fetch

Overview:
- PC-generation and instruction-fetch stage sitting directly upstream of riscv_decode.
- Issues word-aligned requests to instruction memory and accepts redirects from riscv_exec (branch_request/branch_pc).
- Buffers returned instructions in a small FIFO.
- Presents them to decode with the valid/accept handshake decode already uses; replaces free-running PC stimulus with real pipeline control.

Parameters:
- BOOT_VECTOR, 32'h0000_0000, PC loaded on reset (bits[1:0] must be 0)
- FIFO_DEPTH, 2, instruction buffer entries; legal values 2 or 4

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- branch_request_i  in  1  redirect request from exec
- branch_pc_i  in  32  redirect target
- icache_rd_o  out  1  fetch request valid
- icache_pc_o  out  32  fetch address, word aligned
- icache_accept_i  in  1  memory accepts request this cycle
- icache_valid_i  in  1  response valid
- icache_inst_i  in  32  response instruction word
- icache_error_i  in  1  bus error on response
- icache_page_fault_i  in  1  page fault on response
- fetch_out_valid_o  out  1  instruction available to decode
- fetch_out_instr_o  out  32  instruction
- fetch_out_pc_o  out  32  PC of instruction
- fetch_out_fault_fetch_o  out  1  bus-error fault attached
- fetch_out_fault_page_o  out  1  page fault attached
- fetch_in_accept_i  in  1  decode consumes head entry
- squash_decode_o  out  1  one-cycle pulse: decode discards in-flight work

Behaviour:
- Reset (rst_i=1 at edge):
  - pc <= BOOT_VECTOR; FIFO empty; outstanding <= 0; discard <= 0; halted <= 0.
  - All outputs 0, except icache_pc_o = BOOT_VECTOR.
- States: IDLE, REQ, WAIT, HALT.
  - IDLE: enter REQ when FIFO occupancy + outstanding < FIFO_DEPTH.
  - REQ: icache_rd_o=1 and icache_pc_o=pc, both held stable until icache_accept_i. On accept: pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), outstanding <= 1, go to WAIT.
  - WAIT: on icache_valid_i, outstanding <= 0, then REQ if space remains, else IDLE. At most one outstanding request.
  - HALT: entered after a faulting response is pushed. No requests are issued until a redirect.
- First request is asserted the cycle after rst_i deasserts.
- Response push:
  - Entry is {pc_of_request, inst, fault_fetch=icache_error_i, fault_page=icache_page_fault_i}.
  - If either fault bit is set, stored instr is forced to 32'h0.
  - If both are set, both bits are set.
  - Pushed entry is visible on fetch_out_* the next cycle (registered, no bypass).
- Decode handshake:
  - fetch_out_valid_o = FIFO not empty; fetch_out_* show the head entry.
  - Pop when fetch_out_valid_o & fetch_in_accept_i. Push and pop in the same cycle are both performed.
  - Outputs stay stable while valid and not accepted.
- Redirect (branch_request_i=1, highest priority):
  - pc <= {branch_pc_i[31:2],2'b00}; FIFO flushed; HALT cleared; squash_decode_o=1 next cycle only.
  - If in REQ and not yet accepted: request is dropped and REQ re-enters with the new pc the next cycle.
  - If accepted in the same cycle as the redirect: discard <= 1.
  - If in WAIT: discard <= 1; the next response is dropped (not pushed) and discard clears.
  - A response arriving in the same cycle as the redirect is dropped.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: all state cleared. Any response still in flight is ignored because outstanding=0.
- Full: no request issued when occupancy + outstanding == FIFO_DEPTH.

Decomposition:
- Package riscv_fetch_pkg:
  - INSTR_W=32, PC_W=32, BOOT_VECTOR default, NOP constant 32'h0000_0013.
  - State enum {IDLE, REQ, WAIT, HALT}.
  - fetch_entry_t struct {pc, instr, fault_fetch, fault_page}.
- Sub-module riscv_fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/flush, count, full/empty; flush has priority over push.

Test Plan:
- Reset release, memory accepts immediately with 1-cycle response, decode always accepts -> fetch_out_pc_o sequence 0x0, 0x4, 0x8, 0xC; fetch_out_valid_o first high 3 cycles after reset deassert.
- Decode holds fetch_in_accept_i=0 for 10 cycles -> exactly FIFO_DEPTH(2) entries (pc 0x0, 0x4), icache_rd_o low, head stays pc 0x0; releasing accept resumes at pc 0x8.
- branch_request_i=1, branch_pc_i=0x103 while in WAIT -> squash_decode_o one pulse; pending response dropped; next fetch_out_pc_o=0x100, then 0x104.
- Response with icache_error_i=1 at pc 0x20 -> entry instr=0x0, fault_fetch=1; no further icache_rd_o; redirect to 0x40 resumes fetching.
- pc=0xFFFF_FFFC fetched -> next icache_pc_o=0x0000_0000.
- rst_i asserted while in WAIT, response arrives next cycle -> response not pushed; icache_pc_o=BOOT_VECTOR after reset.
